// File: rtl/sr_run_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the sr_cpu run/halt/step sequencer.
package sr_run_ctrl_pkg;

    localparam logic [1:0] RC_HALT = 2'd0;
    localparam logic [1:0] RC_RUN  = 2'd1;
    localparam logic [1:0] RC_STEP = 2'd2;
    localparam logic [1:0] RC_RUNN = 2'd3;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_COUNT = 2'd2
    } runState_t;

endpackage

// File: rtl/sr_run_cnt.sv
// Loadable CNT_W down-counter of remaining CPU cycles; zeroNext flags the edge that reaches 0.
// Priority clr > load > dec; never decrements below zero.
module sr_run_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             dec,
    input  logic             clr,
    output logic             zeroNext
);

    logic [CNT_W-1:0] count;

    assign zeroNext = dec && (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sr_run_ctrl.sv
// Run/halt/step/run-N sequencer driving the sr_cpu clock-enable; counts enabled cycles.
// Optional PC breakpoint stop compiled in with `SR_RUN_CTRL_BREAKPOINT_EN.
module sr_run_ctrl
    import sr_run_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter bit RESET_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic [31:0]      pc,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [31:0]      cycle_cnt
);

    runState_t        state;
    logic [31:0]      cycleCnt;
    logic             brk;
    logic             accept;
    logic             goCmd;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadVal;
    logic             cntDec;
    logic             cntClr;
    logic             zeroNext;

    // Outside HALT only RC_HALT is accepted; everything else waits.
    assign cmd_ready = (state == ST_HALT) || (cmd_op == RC_HALT);
    assign accept    = cmd_valid && cmd_ready;
    assign goCmd     = accept && (state == ST_HALT) &&
                       ((cmd_op == RC_RUN) || (cmd_op == RC_STEP) ||
                        ((cmd_op == RC_RUNN) && (cmd_arg != '0)));

    assign cpu_en    = (state != ST_HALT) && !brk && !rst;
    assign halted    = (state == ST_HALT);
    assign cycle_cnt = cycleCnt;

    assign cntLoad    = goCmd && (cmd_op != RC_RUN);
    assign cntLoadVal = (cmd_op == RC_STEP) ? CNT_W'(1) : cmd_arg;
    assign cntDec     = cpu_en && (state == ST_COUNT);
    assign cntClr     = brk || (accept && (state != ST_HALT));

`ifdef SR_RUN_CTRL_BREAKPOINT_EN
    logic skip;
    logic bpHit;

    // skip lets a resume from the breakpoint PC execute that instruction once.
    assign brk    = bp_en && (pc == bp_addr) && !skip && (state != ST_HALT);
    assign bp_hit = bpHit;

    always_ff @(posedge clk) begin
        if (rst) begin
            skip  <= 1'b0;
            bpHit <= 1'b0;
        end else begin
            if (cpu_en) skip <= 1'b0;
            if (goCmd)  skip <= 1'b1;
            if (accept) bpHit <= 1'b0;
            if (brk)    bpHit <= 1'b1;
        end
    end
`else
    logic unusedBpIn;
    assign unusedBpIn = ^{bp_en, bp_addr, pc};
    assign brk        = 1'b0;
    assign bp_hit     = 1'b0;
`endif

    sr_run_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cntLoad),
        .loadVal  (cntLoadVal),
        .dec      (cntDec),
        .clr      (cntClr),
        .zeroNext (zeroNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET_RUN ? ST_RUN : ST_HALT;
            cycleCnt <= '0;
        end else begin
            if (cpu_en) cycleCnt <= cycleCnt + 32'd1;
            if (brk) begin
                state <= ST_HALT;
            end else begin
                case (state)
                    ST_HALT:  if (goCmd) state <= (cmd_op == RC_RUN) ? ST_RUN : ST_COUNT;
                    ST_RUN:   if (accept) state <= ST_HALT;
                    ST_COUNT: if (accept || zeroNext) state <= ST_HALT;
                    default:  state <= ST_HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_run_ctrl.sv
// Randomized + directed scoreboard bench for sr_run_ctrl against a cycle-budget reference model.
module tb_sr_run_ctrl;
    import sr_run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = RC_HALT;
    logic [15:0] cmd_arg = '0;
    logic [31:0] pc;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [31:0] cycle_cnt;

    always #5 clk = ~clk;

    sr_run_ctrl #(.CNT_W(16), .RESET_RUN(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .pc        (pc),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .cycle_cnt (cycle_cnt)
    );

    // Trivial CPU: fetch PC advances one word on every enabled edge.
    always @(posedge clk) begin
        if (rst) pc <= '0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    typedef struct {
        bit          full;
        bit          en;
        bit          halted;
        bit          ready;
        bit          bpHit;
        logic [31:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: halted flag plus budget of enabled cycles left (-1 = unlimited).
    bit          mHalted = 1'b1;
    int          mLeft   = 0;
    logic [31:0] mCycles = '0;
    bit          mBpHit  = 1'b0;
    bit          mSkip   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("cpu_en", {31'd0, cpu_en}, {31'd0, e.en});
            if (e.full) begin
                chk("halted", {31'd0, halted}, {31'd0, e.halted});
                chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.ready});
                chk("bp_hit", {31'd0, bp_hit}, {31'd0, e.bpHit});
                chk("cycle_cnt", cycle_cnt, e.cycles);
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input logic [15:0] arg, input bit r);
        exp_t e;
        bit   brk;
        bit   acc;
        bit   wasHalted;
        @(posedge clk);
        #1;
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        rst       = r;
        brk = 1'b0;
`ifdef SR_RUN_CTRL_BREAKPOINT_EN
        brk = bp_en && (pc == bp_addr) && !mSkip && !mHalted;
`endif
        e.full   = !r;
        e.en     = !mHalted && !brk && !r;
        e.halted = mHalted;
        e.ready  = mHalted || (op == RC_HALT);
        e.bpHit  = mBpHit;
        e.cycles = mCycles;
        sb.push_back(e);
        if (r) begin
            mHalted = 1'b1; mLeft = 0; mCycles = '0; mBpHit = 1'b0; mSkip = 1'b0;
            return;
        end
        acc       = v && e.ready;
        wasHalted = mHalted;
        if (e.en) begin
            mCycles = mCycles + 32'd1;
            mSkip   = 1'b0;
            if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) mHalted = 1'b1;
            end
        end
        if (acc) mBpHit = 1'b0;
        if (brk) begin
            mHalted = 1'b1; mLeft = 0; mBpHit = 1'b1;
        end else if (acc) begin
            if (wasHalted) begin
                if (op == RC_RUN) begin
                    mHalted = 1'b0; mLeft = -1; mSkip = 1'b1;
                end else if (op == RC_STEP) begin
                    mHalted = 1'b0; mLeft = 1; mSkip = 1'b1;
                end else if (op == RC_RUNN && arg != 16'd0) begin
                    mHalted = 1'b0; mLeft = int'(arg); mSkip = 1'b1;
                end
            end else begin
                mHalted = 1'b1; mLeft = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, RC_HALT, 16'd0, 1'b0);
    endtask

    initial begin
        drive(1'b0, RC_HALT, 16'd0, 1'b1);
        drive(1'b0, RC_HALT, 16'd0, 1'b1);
        idle(10);

        // Three single steps.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, RC_STEP, 16'd0, 1'b0);
            idle(2);
        end

        // RUNN 5 cut short by HALT, then RUNN 0 no-op.
        drive(1'b1, RC_RUNN, 16'd5, 1'b0);
        idle(1);
        drive(1'b1, RC_HALT, 16'd0, 1'b0);
        idle(2);
        drive(1'b1, RC_RUNN, 16'd0, 1'b0);
        idle(3);

        // Free run with a back-pressured STEP held, then HALT.
        drive(1'b1, RC_RUN, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, RC_STEP, 16'd0, 1'b0);
        drive(1'b1, RC_HALT, 16'd0, 1'b0);
        idle(2);

        // HALT colliding with the last COUNT edge.
        drive(1'b1, RC_RUNN, 16'd2, 1'b0);
        idle(1);
        drive(1'b1, RC_HALT, 16'd0, 1'b0);
        idle(2);

        // Reset during RUN and during COUNT with 7 left.
        drive(1'b1, RC_RUN, 16'd0, 1'b0);
        idle(3);
        drive(1'b0, RC_HALT, 16'd0, 1'b1);
        idle(2);
        drive(1'b1, RC_RUNN, 16'd9, 1'b0);
        idle(2);
        drive(1'b0, RC_HALT, 16'd0, 1'b1);
        idle(3);

        // 32-bit wrap of cycle_cnt.
        @(posedge clk);
        force dut.cycleCnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycleCnt;
        mCycles = 32'hFFFF_FFFF;
        drive(1'b1, RC_STEP, 16'd0, 1'b0);
        idle(3);

`ifdef SR_RUN_CTRL_BREAKPOINT_EN
        drive(1'b0, RC_HALT, 16'd0, 1'b1);
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        drive(1'b1, RC_RUN, 16'd0, 1'b0);
        idle(8);
        drive(1'b1, RC_STEP, 16'd0, 1'b0);
        idle(3);
        bp_en = 1'b0;
`endif

        // Random command traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            logic [1:0]  op;
            logic [15:0] arg;
            op  = 2'($urandom_range(0, 3));
            arg = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            drive(1'($urandom_range(0, 1)), op, arg, ($urandom_range(0, 63) == 0));
        end
        idle(10);

        // Maximum RUNN count runs to completion.
        drive(1'b1, RC_HALT, 16'd0, 1'b0);
        drive(1'b1, RC_RUNN, 16'hFFFF, 1'b0);
        idle(65540);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
